shift_reg_arb: RTL
==================

# shift_reg_arb

Controller and round-robin arbiter for the `shift_reg_4bit` serial delay line. Two requesters share one shift register. The block grants one requester at a time and serializes its 4-bit word MSB-first into the register's `in`. It then drains the pipeline, reassembles the word from the register's `out`, and reports completion plus an integrity flag. It wraps the existing `shift_reg_4bit` instance at the next level of hierarchy and drives its `in`; `clr` fans out to both blocks.

## Interface
- DEPTH, 4, number of flop stages in the attached shift register (≥1); sets drain length.
- clk  input  1  clock, all state updates on rising edge.
- clr  input  1  asynchronous, active-low reset; same net drives the shift register's `clr`.
- req0, req1  input  1 each  level request from requester 0/1.
- data0, data1  input  4 each  word to send; sampled only in the arbitration cycle.
- gnt0, gnt1  output  1 each  one-cycle pulse: word accepted; requester drops req after seeing it.
- done0, done1  output  1 each  one-cycle pulse: owner's transfer complete, rx_data/err valid.
- sr_in  output  1  registered serial bit into the shift register `in`.
- sr_out  input  1  serial bit from the shift register `out`.
- rx_data  output  4  word reassembled from sr_out.
- err  output  1  rx_data ≠ transmitted word; valid with done.
- busy  output  1  high in every non-IDLE state.
- owner  output  1  index of current/last granted requester.

## Operation
- FSM has four states: IDLE, SEND, DRAIN, DONE. A transaction cycle counter k runs from 0 to DEPTH+3 across SEND and DRAIN.
- IDLE:
  - No req: stay in IDLE, sr_in=0.
  - Any req: latch the winner's data into tx_word, set owner, and go to SEND with k=0.
  - Arbitration: a single requester always wins. If both request, the winner is the requester not served last (round-robin pointer). After reset the pointer favours req0.
- SEND (k=0..3): sr_in = tx_word[3-k]. gnt_owner is high only in the k=0 cycle.
- DRAIN (k=4..DEPTH+3): sr_in=0.
- Capture:
  - At each edge ending a cycle with DEPTH ≤ k ≤ DEPTH+3, shift sr_out into rx_data: rx_data <= {rx_data[2:0], sr_out}.
  - For DEPTH<4, capture overlaps SEND. This is intended.
- DONE, one cycle:
  - done_owner=1.
  - err = (rx_data ≠ tx_word).
  - Then go to IDLE.
- rx_data and err hold their values until the next DONE. err is meaningful only while done is high.
- req is ignored outside IDLE. A req held through DONE is re-arbitrated in the following IDLE cycle.
- Reset (clr=0, any state, asynchronous):
  - state=IDLE, k=0, pointer→req0 preferred.
  - sr_in, gnt*, done*, busy, err, owner all 0; rx_data=0, tx_word=0.
  - An aborted transaction produces no done. The shift register is cleared by the same net, so no stale bits survive.

## Timing
- Arbitration edge E0 (IDLE sees req) starts the transaction:
  - gnt and sr_in=MSB appear in the cycle after E0.
  - The DONE cycle is DEPTH+4 cycles after the gnt cycle: 8 cycles for DEPTH=4.
- Total occupancy from the gnt cycle to the end of DONE is DEPTH+5 cycles. Add one IDLE cycle, so the back-to-back period is DEPTH+6 cycles: 10 for DEPTH=4.
- A bit driven on sr_in in cycle t appears on sr_out in cycle t+DEPTH.
- All outputs are registered; no combinational path from req/data/sr_out to any output.
- Counter width is ceil(log2(DEPTH+4)).

## Test plan
- **Single transfer:**
  - Stimulus: clr low 7 ns then high, DEPTH=4; req0=1, data0=4'b1011.
  - Required: gnt0 pulse; sr_in = 1,0,1,1 then 0,0,0,0; done0 8 cycles after gnt0; rx_data=4'b1011, err=0; busy low the cycle after done0.
- **Contention:**
  - Stimulus: req0 and req1 rise together, data0=4'h3, data1=4'hC, each req dropped on its gnt.
  - Required: gnt0 first; gnt1 10 cycles later; done0 with rx_data=4'h3, then done1 with rx_data=4'hC.
- **Fairness:**
  - Stimulus: both req held high continuously.
  - Required: grants alternate 0,1,0,1 at a 10-cycle period; owner toggles accordingly.
- **Fault injection:**
  - Stimulus: bench inverts sr_out; data0=4'b0110.
  - Required: rx_data=4'b1001, err=1 with done0.
- **Reset mid-operation:**
  - Stimulus: assert clr low during SEND k=2.
  - Required: all outputs 0 immediately (asynchronously), no done pulse. After release with req1 held, gnt1 arrives 1 cycle later and the transfer completes normally.
- **Parameterization:**
  - Stimulus: DEPTH=2 with a matching 2-stage register; data0=4'hA.
  - Required: done0 6 cycles after gnt0, rx_data=4'hA, err=0.

Source files
------------

// File: rtl/shift_reg_arb.sv
// Round-robin controller for a DEPTH-stage serial delay line: serializes the
// winner's 4-bit word MSB-first, drains the line, and checks the echoed word.
module shift_reg_arb #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] data0,
  input  logic [3:0] data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       sr_in,
  input  logic       sr_out,
  output logic [3:0] rx_data,
  output logic       err,
  output logic       busy,
  output logic       owner
);

  localparam int KW = $clog2(DEPTH + 4);
  localparam logic [KW-1:0] K_SEND_LAST = KW'(3);
  localparam logic [KW-1:0] K_CAP_FIRST = KW'(DEPTH);
  localparam logic [KW-1:0] K_LAST      = KW'(DEPTH + 3);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d, k_nxt;
  logic [3:0]    tx_q, tx_d;
  logic [3:0]    rx_sh_q, rx_sh_d;
  logic [3:0]    rx_q, rx_d;
  logic [3:0]    rx_shift, win_word;
  logic          ptr_q, ptr_d;
  logic          owner_q, owner_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          sr_in_q, sr_in_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          done0_q, done0_d, done1_q, done1_d;
  logic          winner, capture;

  function automatic logic word_bit(input logic [3:0] w, input logic [KW-1:0] k);
    logic [3:0] sh;
    sh = w << k;
    return sh[3];
  endfunction

  // ptr_q names the requester that wins a tie; it always points away from the last one served.
  assign winner   = (req0 & req1) ? ptr_q : req1;
  assign win_word = winner ? data1 : data0;
  assign k_nxt    = k_q + KW'(1);
  assign rx_shift = {rx_sh_q[2:0], sr_out};
  assign capture  = ((state_q == SEND) || (state_q == DRAIN)) && (k_q >= K_CAP_FIRST);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    tx_d    = tx_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
    err_d   = err_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    sr_in_d = 1'b0;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;

    if (capture) rx_sh_d = rx_shift;

    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = SEND;
          k_d     = '0;
          tx_d    = win_word;
          owner_d = winner;
          ptr_d   = ~winner;
          gnt0_d  = ~winner;
          gnt1_d  = winner;
          sr_in_d = win_word[3];
        end
      end
      SEND: begin
        k_d = k_nxt;
        if (k_q == K_SEND_LAST) state_d = DRAIN;
        else                    sr_in_d = word_bit(tx_q, k_nxt);
      end
      DRAIN: begin
        k_d = k_nxt;
        if (k_q == K_LAST) begin
          // The last captured bit is still in flight, so compare against the shifted value.
          state_d = DONE;
          k_d     = '0;
          rx_d    = rx_shift;
          err_d   = (rx_shift != tx_q);
          done0_d = ~owner_q;
          done1_d = owner_q;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      k_q     <= '0;
      tx_q    <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      err_q   <= 1'b0;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
      sr_in_q <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      tx_q    <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      sr_in_q <= sr_in_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign sr_in   = sr_in_q;
  assign rx_data = rx_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign owner   = owner_q;

endmodule
